regfile_wb_arbiter: RTL and testbench

Write-port controller for the 32x32 register file in the pipelined core. It shares the single register-file write port between the pipeline writeback stage and the multi-cycle unit (mul/div/load-miss) using round-robin arbitration. It also keeps a pending-write scoreboard of long-latency destinations, which drives stall/hazard signals back to decode.

---
 rtl/regfile_pkg.sv | 17 +
 rtl/regfile_scoreboard.sv | 50 +++++
 rtl/regfile_wb_arbiter.sv | 110 +++++++++++
 tb/tb_regfile_wb_arbiter.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared types and sizing for the register-file write-port controller.
package regfile_pkg;

    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 5;
    localparam int NUM_REGS = 32;

    typedef logic [ADDR_W-1:0] reg_idx_t;
    typedef logic [DATA_W-1:0] reg_data_t;

    // Which requester owns the round-robin priority or the registered write.
    typedef enum logic {
        SRC_P = 1'b0,
        SRC_M = 1'b1
    } wb_src_e;

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-write scoreboard for long-latency destinations: tracks busy
// registers, blocks WAW issue and flags RAW hazards to decode.
module regfile_scoreboard #(
    parameter int ADDR_W   = 5,
    parameter int NUM_REGS = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                issue_valid,
    input  logic [ADDR_W-1:0]   issue_rd,
    output logic                issue_ready,
    input  logic                clr_en,
    input  logic [ADDR_W-1:0]   clr_rd,
    input  logic [ADDR_W-1:0]   chk_rs1,
    input  logic [ADDR_W-1:0]   chk_rs2,
    output logic                hazard,
    output logic [NUM_REGS-1:0] busy_vec
);

    logic [NUM_REGS-1:0] busy_q;
    logic [NUM_REGS-1:0] busy_d;
    logic                set_en;

    always_comb begin
        issue_ready = (issue_rd == '0) || !busy_q[issue_rd];
        hazard      = (busy_q[chk_rs1] && (chk_rs1 != '0)) ||
                      (busy_q[chk_rs2] && (chk_rs2 != '0));
        set_en      = issue_valid && issue_ready && (issue_rd != '0);

        // Clear first, then set, so a same-index set survives the edge.
        busy_d = busy_q;
        if (clr_en && (clr_rd != '0)) begin
            busy_d[clr_rd] = 1'b0;
        end
        if (set_en) begin
            busy_d[issue_rd] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign busy_vec = busy_q;

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the single register-file write port between pipeline writeback and
// the multi-cycle unit with round-robin arbitration and a registered output.
module regfile_wb_arbiter #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_REGS = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                p_valid,
    output logic                p_ready,
    input  logic [ADDR_W-1:0]   p_rd,
    input  logic [DATA_W-1:0]   p_data,
    input  logic                m_valid,
    output logic                m_ready,
    input  logic [ADDR_W-1:0]   m_rd,
    input  logic [DATA_W-1:0]   m_data,
    input  logic                issue_valid,
    output logic                issue_ready,
    input  logic [ADDR_W-1:0]   issue_rd,
    input  logic [ADDR_W-1:0]   chk_rs1,
    input  logic [ADDR_W-1:0]   chk_rs2,
    output logic                hazard,
    output logic [NUM_REGS-1:0] busy_vec,
    output logic                rf_write_enable,
    output logic [ADDR_W-1:0]   rf_addr_rd,
    output logic [DATA_W-1:0]   rf_data_rd
);

    import regfile_pkg::*;

    wb_src_e             rr_q, rr_d;
    wb_src_e             out_src_q, out_src_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   data_q, data_d;

    logic                grant_p;
    logic                grant_m;
    logic                accept;
    logic [ADDR_W-1:0]   win_rd;
    logic [DATA_W-1:0]   win_data;
    logic                commit_m;

    always_comb begin
        grant_p  = p_valid && (!m_valid || (rr_q == SRC_P));
        grant_m  = m_valid && (!p_valid || (rr_q == SRC_M));
        accept   = grant_p || grant_m;
        win_rd   = grant_m ? m_rd   : p_rd;
        win_data = grant_m ? m_data : p_data;

        // Priority only moves after a contended grant.
        rr_d = rr_q;
        if (p_valid && m_valid) begin
            rr_d = grant_p ? SRC_M : SRC_P;
        end

        we_d      = accept && (win_rd != '0);
        addr_d    = accept ? win_rd   : addr_q;
        data_d    = accept ? win_data : data_q;
        out_src_d = out_src_q;
        if (accept) begin
            out_src_d = grant_m ? SRC_M : SRC_P;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_q      <= SRC_P;
            out_src_q <= SRC_P;
            we_q      <= 1'b0;
            addr_q    <= '0;
            data_q    <= '0;
        end else begin
            rr_q      <= rr_d;
            out_src_q <= out_src_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
        end
    end

    // A write already registered when reset arrives must not reach the file.
    assign rf_write_enable = we_q && !rst;
    assign rf_addr_rd      = addr_q;
    assign rf_data_rd      = data_q;
    assign p_ready         = grant_p;
    assign m_ready         = grant_m;

    // busy clears on the same edge the file commits the multi-cycle result.
    assign commit_m = we_q && (out_src_q == SRC_M);

    regfile_scoreboard #(
        .ADDR_W   (ADDR_W),
        .NUM_REGS (NUM_REGS)
    ) u_scoreboard (
        .clk         (clk),
        .rst         (rst),
        .issue_valid (issue_valid),
        .issue_rd    (issue_rd),
        .issue_ready (issue_ready),
        .clr_en      (commit_m),
        .clr_rd      (addr_q),
        .chk_rs1     (chk_rs1),
        .chk_rs2     (chk_rs2),
        .hazard      (hazard),
        .busy_vec    (busy_vec)
    );

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: arbitration, output register,
// scoreboard timing, x0 handling and reset behaviour.
module tb_regfile_wb_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        p_valid, m_valid, issue_valid;
    logic        p_ready, m_ready, issue_ready;
    logic [4:0]  p_rd, m_rd, issue_rd, chk_rs1, chk_rs2;
    logic [31:0] p_data, m_data;
    logic        hazard;
    logic [31:0] busy_vec;
    logic        rf_write_enable;
    logic [4:0]  rf_addr_rd;
    logic [31:0] rf_data_rd;

    int vectors    = 0;
    int miscompares = 0;

    regfile_wb_arbiter #(
        .DATA_W   (32),
        .ADDR_W   (5),
        .NUM_REGS (32)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .p_valid         (p_valid),
        .p_ready         (p_ready),
        .p_rd            (p_rd),
        .p_data          (p_data),
        .m_valid         (m_valid),
        .m_ready         (m_ready),
        .m_rd            (m_rd),
        .m_data          (m_data),
        .issue_valid     (issue_valid),
        .issue_ready     (issue_ready),
        .issue_rd        (issue_rd),
        .chk_rs1         (chk_rs1),
        .chk_rs2         (chk_rs2),
        .hazard          (hazard),
        .busy_vec        (busy_vec),
        .rf_write_enable (rf_write_enable),
        .rf_addr_rd      (rf_addr_rd),
        .rf_data_rd      (rf_data_rd)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Protocol monitor: decode must never let the pipeline write a pending register.
    always @(negedge clk) begin
        if (!rst && p_valid && p_ready && (p_rd != 5'd0)) begin
            assert (busy_vec[p_rd] == 1'b0) else begin
                miscompares++;
                $error("FAIL p_write_to_busy: rd %0d busy_vec %0h", p_rd, busy_vec);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        p_valid = 1'b1; p_rd = 5'd3; p_data = 32'h1;
        m_valid = 1'b0; m_rd = 5'd0; m_data = 32'h0;
        issue_valid = 1'b0; issue_rd = 5'd0;
        chk_rs1 = 5'd0; chk_rs2 = 5'd0;

        // Reset held two cycles with a pipeline request pending.
        tick();
        tick();
        chk("rst_we",   {31'd0, rf_write_enable}, 32'd0);
        chk("rst_addr", {27'd0, rf_addr_rd}, 32'd0);
        chk("rst_data", rf_data_rd, 32'd0);
        chk("rst_busy", busy_vec, 32'd0);
        chk("rst_hazard", {31'd0, hazard}, 32'd0);

        rst = 1'b0;
        #1;
        chk("post_rst_p_ready", {31'd0, p_ready}, 32'd1);
        tick();
        chk("post_rst_we",   {31'd0, rf_write_enable}, 32'd1);
        chk("post_rst_addr", {27'd0, rf_addr_rd}, 32'd3);
        chk("post_rst_data", rf_data_rd, 32'h1);

        // Single pipeline write.
        p_rd = 5'd5; p_data = 32'hDEADBEEF;
        #1;
        chk("single_p_ready", {31'd0, p_ready}, 32'd1);
        chk("single_m_ready", {31'd0, m_ready}, 32'd0);
        tick();
        p_valid = 1'b0;
        chk("single_we",   {31'd0, rf_write_enable}, 32'd1);
        chk("single_addr", {27'd0, rf_addr_rd}, 32'd5);
        chk("single_data", rf_data_rd, 32'hDEADBEEF);
        tick();
        chk("idle_we",   {31'd0, rf_write_enable}, 32'd0);
        chk("idle_addr_hold", {27'd0, rf_addr_rd}, 32'd5);
        chk("idle_data_hold", rf_data_rd, 32'hDEADBEEF);

        // Contention: P, M, P, M.
        p_valid = 1'b1; p_rd = 5'd1; p_data = 32'hA1;
        m_valid = 1'b1; m_rd = 5'd2; m_data = 32'hB2;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("cont_p_ready", {31'd0, p_ready}, (i % 2 == 0) ? 32'd1 : 32'd0);
            chk("cont_m_ready", {31'd0, m_ready}, (i % 2 == 1) ? 32'd1 : 32'd0);
            chk("cont_not_both", {31'd0, p_ready & m_ready}, 32'd0);
            tick();
            chk("cont_addr", {27'd0, rf_addr_rd}, (i % 2 == 0) ? 32'd1 : 32'd2);
            chk("cont_data", rf_data_rd, (i % 2 == 0) ? 32'hA1 : 32'hB2);
        end

        // Uncontended M grant leaves priority with P.
        p_valid = 1'b0;
        #1;
        chk("uncont_m_ready", {31'd0, m_ready}, 32'd1);
        tick();
        p_valid = 1'b1;
        #1;
        chk("after_uncont_p_ready", {31'd0, p_ready}, 32'd1);
        chk("after_uncont_m_ready", {31'd0, m_ready}, 32'd0);
        tick();
        p_valid = 1'b0; m_valid = 1'b0;
        tick();

        // Scoreboard set / hazard / WAW / clear timing.
        issue_valid = 1'b1; issue_rd = 5'd7;
        #1;
        chk("issue7_ready", {31'd0, issue_ready}, 32'd1);
        tick();
        issue_valid = 1'b0;
        chk("busy7_set", busy_vec, 32'h0000_0080);
        chk_rs1 = 5'd7; chk_rs2 = 5'd0;
        #1;
        chk("hazard_rs1", {31'd0, hazard}, 32'd1);
        chk("waw_block", {31'd0, issue_ready}, 32'd0);
        chk_rs1 = 5'd8; chk_rs2 = 5'd7;
        #1;
        chk("hazard_rs2", {31'd0, hazard}, 32'd1);
        chk_rs2 = 5'd6;
        #1;
        chk("no_hazard", {31'd0, hazard}, 32'd0);
        m_valid = 1'b1; m_rd = 5'd7; m_data = 32'h77;
        #1;
        chk("m7_ready", {31'd0, m_ready}, 32'd1);
        tick();
        m_valid = 1'b0;
        chk("m7_we", {31'd0, rf_write_enable}, 32'd1);
        chk("m7_addr", {27'd0, rf_addr_rd}, 32'd7);
        chk("busy7_during_write", busy_vec, 32'h0000_0080);
        tick();
        chk("busy7_cleared", busy_vec, 32'd0);
        chk("m7_we_off", {31'd0, rf_write_enable}, 32'd0);
        #1;
        chk("issue7_ready_again", {31'd0, issue_ready}, 32'd1);

        // x0 handling.
        p_valid = 1'b1; p_rd = 5'd0; p_data = 32'h55;
        #1;
        chk("p_x0_ready", {31'd0, p_ready}, 32'd1);
        tick();
        p_valid = 1'b0;
        chk("p_x0_we", {31'd0, rf_write_enable}, 32'd0);
        m_valid = 1'b1; m_rd = 5'd0; m_data = 32'h66;
        #1;
        chk("m_x0_ready", {31'd0, m_ready}, 32'd1);
        tick();
        m_valid = 1'b0;
        chk("m_x0_we", {31'd0, rf_write_enable}, 32'd0);
        issue_valid = 1'b1; issue_rd = 5'd0;
        #1;
        chk("issue_x0_ready", {31'd0, issue_ready}, 32'd1);
        tick();
        issue_valid = 1'b0;
        chk_rs1 = 5'd0; chk_rs2 = 5'd0;
        #1;
        chk("issue_x0_busy", busy_vec, 32'd0);
        chk("hazard_x0", {31'd0, hazard}, 32'd0);

        // Reset while an accepted M write is in flight with busy[9] set.
        issue_valid = 1'b1; issue_rd = 5'd9;
        tick();
        issue_valid = 1'b0;
        chk("busy9_set", busy_vec, 32'h0000_0200);
        m_valid = 1'b1; m_rd = 5'd9; m_data = 32'h99;
        #1;
        chk("m9_ready", {31'd0, m_ready}, 32'd1);
        tick();
        m_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("rst_mid_we", {31'd0, rf_write_enable}, 32'd0);
        tick();
        chk("rst_mid_busy", busy_vec, 32'd0);
        chk("rst_mid_we_after", {31'd0, rf_write_enable}, 32'd0);
        rst = 1'b0;
        tick();
        chk("post_mid_we", {31'd0, rf_write_enable}, 32'd0);
        issue_rd = 5'd9;
        #1;
        chk("post_mid_issue_ready", {31'd0, issue_ready}, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
